// File: rtl/seg_rx.sv
// seg_rx: decodes active-low 7-segment codes into a show-ahead FIFO of {err, digit}
module seg_rx #(
  parameter int DEPTH = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [6:0]               iSeg,
  input  logic                     iValid,
  output logic                     oReady,
  output logic [3:0]               oDigit,
  output logic                     oErr,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic [7:0]               oErrCnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [6:0]    p;
  logic [4:0]    dec, head;
  logic          push, pop;
  always_comb begin
    p = ~iSeg;
    case (p)
      7'b011_1111: dec = 5'h00;
      7'b000_0110: dec = 5'h01;
      7'b101_1011: dec = 5'h02;
      7'b100_1111: dec = 5'h03;
      7'b110_0110: dec = 5'h04;
      7'b110_1101: dec = 5'h05;
      7'b111_1101: dec = 5'h06;
      7'b000_0111: dec = 5'h07;
      7'b111_1111: dec = 5'h08;
      7'b110_1111: dec = 5'h09;
      default:     dec = 5'h1F;
    endcase
  end
  // full is never bypassed by a same-cycle pop; reset blocks both sides
  assign oReady = !iRst && (count_q < CW'(DEPTH));
  assign oValid = count_q != '0;
  assign push   = iValid && oReady;
  assign pop    = !iRst && oValid && iReady;
  assign head   = mem_q[rd_ptr_q];
  assign oDigit = oValid ? head[3:0] : 4'h0;
  assign oErr   = oValid && head[4];
  assign oCount  = count_q;
  assign oErrCnt = err_cnt_q;
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    err_cnt_d = (push && dec[4] && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  always_ff @(posedge iClk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end
endmodule

// File: tb/tb_seg_rx.sv
// tb_seg_rx: directed checks of seg_rx decode, FIFO ordering, reset and error counter
module tb_seg_rx;
  logic       iClk = 1'b0, iRst = 1'b1, iValid = 1'b0, iReady = 1'b0;
  logic [6:0] iSeg = 7'h7F;
  logic       oReady, oErr, oValid;
  logic [3:0] oDigit;
  logic [2:0] oCount;
  logic [7:0] oErrCnt;
  int passed = 0, total = 0;

  seg_rx #(.DEPTH(4)) dut (
    .iClk(iClk), .iRst(iRst), .iSeg(iSeg), .iValid(iValid), .oReady(oReady),
    .oDigit(oDigit), .oErr(oErr), .oValid(oValid), .iReady(iReady),
    .oCount(oCount), .oErrCnt(oErrCnt)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic push1(input logic [6:0] seg);
    iSeg = seg; iValid = 1'b1;
    step();
    iValid = 1'b0;
  endtask

  initial begin
    step();
    chk("rst_ready", oReady, 0);
    chk("rst_count", oCount, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_digit", oDigit, 0);
    chk("rst_err", oErr, 0);
    chk("rst_errcnt", oErrCnt, 0);
    iRst = 1'b0;
    #1;
    chk("ready_after_rst", oReady, 1);

    push1(7'b100_0000);
    chk("cap_valid", oValid, 1);
    chk("cap_digit", oDigit, 0);
    chk("cap_err", oErr, 0);
    chk("cap_count", oCount, 1);
    iReady = 1'b1; step(); iReady = 1'b0;
    chk("cap_drained", oValid, 0);

    push1(7'b000_0000);
    push1(7'b111_1001);
    push1(7'b100_0000);
    push1(7'b001_1001);
    chk("fill_count", oCount, 4);
    chk("fill_ready", oReady, 0);
    push1(7'b100_0000);
    chk("fill_5th_rejected", oCount, 4);
    chk("fill_errcnt", oErrCnt, 0);
    iReady = 1'b1;
    chk("drain_d0", oDigit, 8); step();
    chk("drain_d1", oDigit, 1); step();
    chk("drain_d2", oDigit, 0); step();
    chk("drain_d3", oDigit, 4); step();
    chk("drain_empty", oValid, 0);
    chk("drain_digit0", oDigit, 0);
    step();
    chk("empty_pop_ignored", oCount, 0);
    iReady = 1'b0;

    push1(7'b111_1111);
    chk("blank_digit", oDigit, 4'hF);
    chk("blank_err", oErr, 1);
    chk("blank_errcnt", oErrCnt, 1);
    iReady = 1'b1; step(); iReady = 1'b0;

    push1(7'b010_0100);
    push1(7'b011_0000);
    chk("pp_count_pre", oCount, 2);
    iReady = 1'b1;
    push1(7'b001_0010);
    chk("pp_count1", oCount, 2);
    chk("pp_head1", oDigit, 3);
    push1(7'b000_0010);
    chk("pp_count2", oCount, 2);
    chk("pp_head2", oDigit, 5);
    step();
    chk("pp_head3", oDigit, 6);
    step();
    chk("pp_empty", oValid, 0);
    iReady = 1'b0;

    push1(7'h7F);
    iReady = 1'b1; push1(7'h7F); iReady = 1'b0;
    push1(7'h7F);
    push1(7'h7F);
    chk("mid_count", oCount, 3);
    chk("mid_errcnt", oErrCnt, 5);
    iRst = 1'b1; step(); iRst = 1'b0; #1;
    chk("mid_rst_count", oCount, 0);
    chk("mid_rst_valid", oValid, 0);
    chk("mid_rst_errcnt", oErrCnt, 0);
    chk("mid_rst_ready", oReady, 1);

    iSeg = 7'h7F; iValid = 1'b1; iReady = 1'b1;
    for (int i = 0; i < 254; i++) step();
    chk("sat_254", oErrCnt, 254);
    for (int i = 0; i < 6; i++) step();
    chk("sat_260", oErrCnt, 255);
    chk("sat_count", oCount, 1);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", oErrCnt, 255);
    iValid = 1'b0;
    step();
    chk("sat_drained", oValid, 0);
    iReady = 1'b0;

    push1(7'b111_1000);
    chk("dec_7", oDigit, 7);
    iReady = 1'b1; step(); iReady = 1'b0;
    push1(7'b001_0000);
    chk("dec_9", oDigit, 9);
    chk("dec_9_err", oErr, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
